// File: rtl/q_learning_pkg.sv
// Shared widths and FSM encoding for the Q-learning update sequencer.
package q_learning_pkg;

    localparam int STATE_W = 18;
    localparam int ACT_W   = 4;
    localparam int NUM_ACT = 9;
    localparam int Q_W     = 8;
    localparam int CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_S  = 3'd1,
        RD_NS = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/action_onehot.sv
// Action index to one-hot RAM write-enable decode, with a legality flag.
module action_onehot
    import q_learning_pkg::*;
(
    input  logic [ACT_W-1:0]   idx,
    output logic [NUM_ACT-1:0] onehot,
    output logic               legal
);

    // Out-of-range actions decode to all-zero so no RAM is ever written.
    assign legal  = (idx < ACT_W'(NUM_ACT));
    assign onehot = legal ? (NUM_ACT'(1) << idx) : '0;

endmodule

// File: rtl/q_update_sequencer.sv
// Sequences one Q-learning update through the shared action-RAM / max / updater
// datapath: read Q(s,*), read Q(s',*), write the new Q(s,a), then report done.
module q_update_sequencer
    import q_learning_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cfg_we,
    input  logic [Q_W-1:0]     cfg_gamma,
    input  logic [Q_W-1:0]     cfg_alfa,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [STATE_W-1:0] req_state,
    input  logic [ACT_W-1:0]   req_action,
    input  logic [STATE_W-1:0] req_next_state,
    input  logic [Q_W-1:0]     req_reward,
    output logic [STATE_W-1:0] dp_read_addr,
    output logic [STATE_W-1:0] dp_write_addr,
    output logic [NUM_ACT-1:0] dp_we,
    output logic [ACT_W-1:0]   dp_sel,
    output logic [Q_W-1:0]     dp_reward,
    output logic [Q_W-1:0]     dp_gamma,
    output logic [Q_W-1:0]     dp_alfa,
    input  logic [Q_W-1:0]     dp_q_new,
    output logic               done,
    output logic [Q_W-1:0]     q_new,
    output logic               err,
    output logic [CNT_W-1:0]   update_count
);

    seq_state_t         state;
    logic [STATE_W-1:0] s_r;
    logic [STATE_W-1:0] ns_r;
    logic [ACT_W-1:0]   a_r;
    logic [NUM_ACT-1:0] a_onehot;
    logic               a_legal;
    logic [Q_W-1:0]     gamma_r;
    logic [Q_W-1:0]     alfa_r;

    action_onehot u_action_onehot (
        .idx    (a_r),
        .onehot (a_onehot),
        .legal  (a_legal)
    );

    // Config is writable in any state; a write lands on the next edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            gamma_r <= '0;
            alfa_r  <= '0;
        end else if (cfg_we) begin
            gamma_r <= cfg_gamma;
            alfa_r  <= cfg_alfa;
        end
    end

    assign dp_gamma = gamma_r;
    assign dp_alfa  = alfa_r;

    // NOTE: non-blocking assignments throughout so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            dp_we         <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            q_new         <= '0;
            update_count  <= '0;
            dp_read_addr  <= '0;
            dp_write_addr <= '0;
            dp_sel        <= '0;
            dp_reward     <= '0;
            s_r           <= '0;
            ns_r          <= '0;
            a_r           <= '0;
        end else begin
            // Pulse outputs default low; only their owning state raises them.
            dp_we <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        s_r          <= req_state;
                        ns_r         <= req_next_state;
                        a_r          <= req_action;
                        dp_reward    <= req_reward;
                        dp_read_addr <= req_state;
                        req_ready    <= 1'b0;
                        state        <= RD_S;
                    end
                end
                RD_S: begin
                    dp_read_addr <= ns_r;
                    state        <= RD_NS;
                end
                RD_NS: begin
                    // RAM output now trails the address by one cycle, so in
                    // WRITE the delay stage holds Q(s,*) and the RAM Q(s',*).
                    dp_write_addr <= s_r;
                    dp_sel        <= a_r;
                    dp_we         <= a_onehot;
                    state         <= WRITE;
                end
                WRITE: begin
                    q_new <= dp_q_new;
                    done  <= 1'b1;
                    err   <= ~a_legal;
                    if (a_legal) begin
                        update_count <= update_count + 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q_update_sequencer.sv
// Randomized self-checking bench: a transaction-level model of the update
// sequence plus a small behavioural action-RAM / max / updater datapath.
module tb_q_update_sequencer;
    import q_learning_pkg::*;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               cfg_we;
    logic [Q_W-1:0]     cfg_gamma, cfg_alfa;
    logic               req_valid, req_ready;
    logic [STATE_W-1:0] req_state, req_next_state;
    logic [ACT_W-1:0]   req_action;
    logic [Q_W-1:0]     req_reward;
    logic [STATE_W-1:0] dp_read_addr, dp_write_addr;
    logic [NUM_ACT-1:0] dp_we;
    logic [ACT_W-1:0]   dp_sel;
    logic [Q_W-1:0]     dp_reward, dp_gamma, dp_alfa, dp_q_new;
    logic               done, err;
    logic [Q_W-1:0]     q_new;
    logic [CNT_W-1:0]   update_count;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    q_update_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cfg_we         (cfg_we),
        .cfg_gamma      (cfg_gamma),
        .cfg_alfa       (cfg_alfa),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_state      (req_state),
        .req_action     (req_action),
        .req_next_state (req_next_state),
        .req_reward     (req_reward),
        .dp_read_addr   (dp_read_addr),
        .dp_write_addr  (dp_write_addr),
        .dp_we          (dp_we),
        .dp_sel         (dp_sel),
        .dp_reward      (dp_reward),
        .dp_gamma       (dp_gamma),
        .dp_alfa        (dp_alfa),
        .dp_q_new       (dp_q_new),
        .done           (done),
        .q_new          (q_new),
        .err            (err),
        .update_count   (update_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [Q_W-1:0] init_val(input int i, input int k);
        return Q_W'(i * 16 + k * 3);
    endfunction

    // Updater: q + alfa*(r + gamma*maxq - q), all fractions in 1/256 units.
    function automatic logic [Q_W-1:0] upd(input int qsa, input int maxq, input int r,
                                           input int g, input int al);
        int td, q;
        td = r + ((g * maxq) >>> 8) - qsa;
        q  = qsa + ((al * td) >>> 8);
        return Q_W'(q);
    endfunction

    // ---------------- behavioural datapath (16 states modelled) -------------
    logic [Q_W-1:0] mem     [16][NUM_ACT];
    logic [Q_W-1:0] ram_out [NUM_ACT];
    logic [Q_W-1:0] dly     [NUM_ACT];
    bit             mem_init = 1'b0;
    int             mx_c, qsa_c;

    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++)
                for (int k = 0; k < NUM_ACT; k++)
                    mem[i][k] <= init_val(i, k);
            for (int k = 0; k < NUM_ACT; k++) begin
                ram_out[k] <= '0;
                dly[k]     <= '0;
            end
            mem_init <= 1'b1;
        end else begin
            ram_out <= mem[dp_read_addr[3:0]];
            dly     <= ram_out;
            for (int k = 0; k < NUM_ACT; k++)
                if (dp_we[k]) mem[dp_write_addr[3:0]][k] <= dp_q_new;
        end
    end

    always_comb begin
        mx_c  = 0;
        qsa_c = 0;
        for (int k = 0; k < NUM_ACT; k++)
            if (int'(ram_out[k]) > mx_c) mx_c = int'(ram_out[k]);
        if (int'(dp_sel) < NUM_ACT) qsa_c = int'(dly[int'(dp_sel)]);
        dp_q_new = upd(qsa_c, mx_c, int'(dp_reward), int'(dp_gamma), int'(dp_alfa));
    end

    // ---------------- transaction-level reference model ---------------------
    int                 m_phase = 0;
    logic [Q_W-1:0]     ref_q [16][NUM_ACT];
    bit                 ref_init = 1'b0;
    logic [STATE_W-1:0] t_s, t_ns;
    int                 t_a;
    logic [STATE_W-1:0] e_read_addr, e_write_addr;
    logic [ACT_W-1:0]   e_sel;
    logic [NUM_ACT-1:0] e_we;
    logic               e_done, e_err;
    logic [Q_W-1:0]     e_q_new, e_reward, e_gamma, e_alfa;
    logic [CNT_W-1:0]   e_count;
    logic [CNT_W-1:0]   count_bias = '0;

    always @(posedge clock) begin
        int qsa, mx;
        if (!ref_init) begin
            for (int i = 0; i < 16; i++)
                for (int k = 0; k < NUM_ACT; k++)
                    ref_q[i][k] = init_val(i, k);
            ref_init = 1'b1;
        end
        if (!reset_n) begin
            m_phase = 0;
            e_read_addr = '0; e_write_addr = '0; e_sel = '0; e_we = '0;
            e_done = 1'b0; e_err = 1'b0; e_q_new = '0; e_reward = '0;
            e_gamma = '0; e_alfa = '0; e_count = '0;
        end else begin
            e_done = 1'b0;
            e_err  = 1'b0;
            e_we   = '0;
            case (m_phase)
                0: if (req_valid) begin
                    t_s = req_state; t_ns = req_next_state; t_a = int'(req_action);
                    e_reward = req_reward;
                    e_read_addr = req_state;
                    m_phase = 1;
                end
                1: begin e_read_addr = t_ns; m_phase = 2; end
                2: begin
                    e_write_addr = t_s;
                    e_sel = ACT_W'(t_a);
                    e_we = (t_a < NUM_ACT) ? NUM_ACT'(1 << t_a) : '0;
                    m_phase = 3;
                end
                3: begin
                    mx = 0;
                    for (int k = 0; k < NUM_ACT; k++)
                        if (int'(ref_q[t_ns[3:0]][k]) > mx) mx = int'(ref_q[t_ns[3:0]][k]);
                    qsa = (t_a < NUM_ACT) ? int'(ref_q[t_s[3:0]][t_a]) : 0;
                    e_q_new = upd(qsa, mx, int'(e_reward), int'(e_gamma), int'(e_alfa));
                    e_done = 1'b1;
                    e_err = (t_a >= NUM_ACT);
                    if (t_a < NUM_ACT) begin
                        ref_q[t_s[3:0]][t_a] = e_q_new;
                        e_count = e_count + 1'b1;
                    end
                    m_phase = 4;
                end
                default: m_phase = 0;
            endcase
            if (cfg_we) begin
                e_gamma = cfg_gamma;
                e_alfa  = cfg_alfa;
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clock) begin
        if (cmp_en) begin
            check("req_ready",     32'(req_ready),     32'(m_phase == 0));
            check("dp_read_addr",  32'(dp_read_addr),  32'(e_read_addr));
            check("dp_write_addr", 32'(dp_write_addr), 32'(e_write_addr));
            check("dp_sel",        32'(dp_sel),        32'(e_sel));
            check("dp_we",         32'(dp_we),         32'(e_we));
            check("dp_reward",     32'(dp_reward),     32'(e_reward));
            check("dp_gamma",      32'(dp_gamma),      32'(e_gamma));
            check("dp_alfa",       32'(dp_alfa),       32'(e_alfa));
            check("done",          32'(done),          32'(e_done));
            check("err",           32'(err),           32'(e_err));
            check("q_new",         32'(q_new),         32'(e_q_new));
            check("update_count",  32'(update_count),  32'(CNT_W'(e_count + count_bias)));
        end
    end

    task automatic send(input int s, input int a, input int ns, input int r);
        req_state      = STATE_W'(s);
        req_action     = ACT_W'(a);
        req_next_state = STATE_W'(ns);
        req_reward     = Q_W'(r);
        req_valid      = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) check("idle_timeout", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int done_t[$];
        int accepts;
        bit saw_we;

        reset_n = 1'b0; cfg_we = 1'b0; cfg_gamma = '0; cfg_alfa = '0;
        req_valid = 1'b0; req_state = '0; req_action = '0;
        req_next_state = '0; req_reward = '0;

        // Reset then idle.
        @(negedge clock);
        cmp_en = 1'b1;
        @(negedge clock);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_we",    32'(dp_we),     32'd0);
        check("rst_count", 32'(update_count), 32'd0);
        check("rst_qnew",  32'(q_new),     32'd0);
        reset_n = 1'b1;

        // Single update with hand-computed expectations.
        cfg_we = 1'b1; cfg_gamma = 8'h80; cfg_alfa = 8'h40;
        @(negedge clock);
        cfg_we = 1'b0;
        send(1, 4, 5, 8'h10);
        @(negedge clock);
        req_valid = 1'b0;
        check("single_rd0", 32'(dp_read_addr), 32'h00001);
        @(negedge clock);
        check("single_rd1", 32'(dp_read_addr), 32'h00005);
        @(negedge clock);
        check("single_rd2", 32'(dp_read_addr), 32'h00005);
        check("single_we",  32'(dp_we), 32'b000010000);
        @(negedge clock);
        check("single_done", 32'(done), 32'd1);
        check("single_qnew", 32'(q_new), 32'h26);
        @(negedge clock);
        check("single_we_off", 32'(dp_we), 32'd0);
        check("single_count",  32'(update_count), 32'd1);

        // Back-to-back with s == s'.
        send(2, 1, 2, 8'h30);
        accepts = 0;
        for (int c = 0; c < 40 && (accepts < 3 || done_t.size() < 3); c++) begin
            if (req_valid && req_ready) accepts++;
            @(negedge clock);
            if (done) done_t.push_back(c);
            if (accepts == 3) req_valid = 1'b0;
        end
        check("b2b_dones", 32'(done_t.size()), 32'd3);
        if (done_t.size() == 3) begin
            check("b2b_gap1", 32'(done_t[1] - done_t[0]), 32'd5);
            check("b2b_gap2", 32'(done_t[2] - done_t[1]), 32'd5);
        end
        @(negedge clock);
        check("b2b_count", 32'(update_count), 32'd4);

        // Illegal action.
        wait_idle();
        send(3, 9, 7, 8'h05);
        saw_we = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (dp_we != '0) saw_we = 1'b1;
            @(negedge clock);
        end
        check("illegal_we",   32'(saw_we), 32'd0);
        check("illegal_done", 32'(done), 32'd1);
        check("illegal_err",  32'(err),  32'd1);
        @(negedge clock);
        check("illegal_count", 32'(update_count), 32'd4);

        // Reset asserted during RD_NS.
        wait_idle();
        send(6, 2, 8, 8'h44);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("midrst_ready", 32'(req_ready), 32'd1);
        saw_we = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (dp_we != '0 || done) saw_we = 1'b1;
            @(negedge clock);
        end
        check("midrst_quiet", 32'(saw_we), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            cfg_we = 1'b0;
            if (req_ready && ($urandom_range(0, 7) == 0)) begin
                cfg_we    = 1'b1;
                cfg_gamma = Q_W'($urandom);
                cfg_alfa  = Q_W'($urandom);
            end
            send($urandom_range(0, 15), $urandom_range(0, 10),
                 $urandom_range(0, 15), $urandom_range(0, 255));
            req_valid = ($urandom_range(0, 2) != 0);
            @(negedge clock);
        end
        cfg_we = 1'b0;
        req_valid = 1'b0;

        // Counter wrap via preload.
        wait_idle();
        #1;
        force dut.update_count = 16'hFFFF;
        count_bias = CNT_W'(32'hFFFF - 32'(e_count));
        @(posedge clock);
        #1;
        release dut.update_count;
        @(negedge clock);
        send(4, 0, 9, 8'h20);
        @(negedge clock);
        req_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("wrap_done",  32'(done), 32'd1);
        check("wrap_count", 32'(update_count), 32'd0);
        repeat (2) @(negedge clock);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
